// File: rtl/comparator_arbiter_pkg.sv
// Shared definitions for the comparator arbiter slice: requester count,
// operand width, index width and the arbiter state encoding.
package comparator_arbiter_pkg;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int IDX_W      = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    REPORT  = 2'd2
  } state_e;
endpackage

// File: rtl/comparator_arbiter_if.sv
// Requester-side bus of the comparator arbiter.
//   master : requester block (drives Req_In / operands, sees grant + result)
//   slave  : comparator_arbiter
// Operands are packed per requester: requester i on [16i+15:16i].
interface comparator_arbiter_if;
  import comparator_arbiter_pkg::*;

  logic [NUM_REQ-1:0]            Req_In;
  logic [NUM_REQ*DATA_WIDTH-1:0] Data_A_In;
  logic [NUM_REQ*DATA_WIDTH-1:0] Data_B_In;
  logic [NUM_REQ-1:0]            Gnt_Out;
  logic                          Busy_Out;
  logic [NUM_REQ-1:0]            Result_Valid_Out;
  logic                          A_gt_B_Out;
  logic                          A_eq_B_Out;
  logic                          A_lt_B_Out;

  modport master (
    output Req_In, Data_A_In, Data_B_In,
    input  Gnt_Out, Busy_Out, Result_Valid_Out, A_gt_B_Out, A_eq_B_Out, A_lt_B_Out
  );

  modport slave (
    input  Req_In, Data_A_In, Data_B_In,
    output Gnt_Out, Busy_Out, Result_Valid_Out, A_gt_B_Out, A_eq_B_Out, A_lt_B_Out
  );
endinterface

// File: rtl/comparator_arbiter_cmp.sv
// Comparator_16_Bit: unsigned 16-bit magnitude comparator.
//   Enable_In      : outputs driven only while high, high-Z otherwise
//   A_In / B_In    : operands
//   A_*_B_Out      : exactly one flag high while enabled
module Comparator_16_Bit (
  input  logic        Enable_In,
  input  logic [15:0] A_In,
  input  logic [15:0] B_In,
  output logic        A_gt_B_Out,
  output logic        A_eq_B_Out,
  output logic        A_lt_B_Out
);
  assign A_gt_B_Out = Enable_In ? (A_In >  B_In) : 1'bz;
  assign A_eq_B_Out = Enable_In ? (A_In == B_In) : 1'bz;
  assign A_lt_B_Out = Enable_In ? (A_In <  B_In) : 1'bz;
endmodule

// File: rtl/comparator_arbiter.sv
// comparator_arbiter: round-robin share of one 16-bit comparator among
// NUM_REQ requesters. IDLE -> COMPARE -> REPORT, one comparison per 3 cycles.
//   Clock_In   : clock, rising edge
//   Reset_n_In : async active-low reset
//   bus        : requester bus (slave side), see comparator_arbiter_if
module comparator_arbiter #(
  parameter int NUM_REQ    = comparator_arbiter_pkg::NUM_REQ,
  parameter int DATA_WIDTH = comparator_arbiter_pkg::DATA_WIDTH
) (
  input  logic                 Clock_In,
  input  logic                 Reset_n_In,
  comparator_arbiter_if.slave  bus
);
  import comparator_arbiter_pkg::*;

  state_e                state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      win;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [NUM_REQ-1:0]    gnt, rv;
  logic                  busy, gt, eq, lt;
  logic                  cmp_gt, cmp_eq, cmp_lt;

  // Round-robin search from ptr upward; index arithmetic wraps at NUM_REQ
  // because NUM_REQ is a power of two.
  logic [IDX_W-1:0] win_c;
  logic             any_c;
  always_comb begin
    logic [IDX_W-1:0] idx;
    win_c = '0;
    any_c = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!any_c && bus.Req_In[idx]) begin
        win_c = idx;
        any_c = 1'b1;
      end
    end
  end

  // Fed only from captured operands so live bus changes cannot disturb it.
  Comparator_16_Bit u_cmp (
    .Enable_In  (state == COMPARE),
    .A_In       (op_a),
    .B_In       (op_b),
    .A_gt_B_Out (cmp_gt),
    .A_eq_B_Out (cmp_eq),
    .A_lt_B_Out (cmp_lt)
  );

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      gnt   <= '0;
      rv    <= '0;
      busy  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rv <= '0;
          if (any_c) begin
            state <= COMPARE;
            win   <= win_c;
            op_a  <= bus.Data_A_In[win_c*DATA_WIDTH +: DATA_WIDTH];
            op_b  <= bus.Data_B_In[win_c*DATA_WIDTH +: DATA_WIDTH];
            gnt   <= NUM_REQ'(1) << win_c;
            busy  <= 1'b1;
          end
        end
        COMPARE: begin
          // Comparator is enabled in this state, so its outputs are driven.
          state <= REPORT;
          gnt   <= '0;
          rv    <= NUM_REQ'(1) << win;
          gt    <= cmp_gt;
          eq    <= cmp_eq;
          lt    <= cmp_lt;
        end
        REPORT: begin
          state <= IDLE;
          rv    <= '0;
          busy  <= 1'b0;
          ptr   <= win + IDX_W'(1);
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          rv    <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Gnt_Out          = gnt;
  assign bus.Busy_Out         = busy;
  assign bus.Result_Valid_Out = rv;
  assign bus.A_gt_B_Out       = gt;
  assign bus.A_eq_B_Out       = eq;
  assign bus.A_lt_B_Out       = lt;
endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed bench for comparator_arbiter; expected values hand-computed.
module tb_comparator_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  comparator_arbiter_if bus();

  comparator_arbiter dut (
    .Clock_In   (clk),
    .Reset_n_In (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.Data_A_In[i*16 +: 16] = a;
    bus.Data_B_In[i*16 +: 16] = b;
  endtask

  function automatic logic [2:0] flags();
    return {bus.A_gt_B_Out, bus.A_eq_B_Out, bus.A_lt_B_Out};
  endfunction

  initial begin
    logic [3:0]  req027;
    logic [2:0]  exp027 [4];
    bus.Req_In    = '0;
    bus.Data_A_In = '0;
    bus.Data_B_In = '0;

    // Reset state
    #12;
    chk("rst_gnt",   32'(bus.Gnt_Out), 0);
    chk("rst_rv",    32'(bus.Result_Valid_Out), 0);
    chk("rst_busy",  32'(bus.Busy_Out), 0);
    chk("rst_flags", 32'(flags()), 0);

    // Single request on index 2: 0x0001 vs 0x0000 -> gt
    @(negedge clk); rst_n = 1'b1;
    bus.Req_In = 4'b0100;
    set_ops(2, 16'h0001, 16'h0000);
    step();
    chk("s2_gnt",  32'(bus.Gnt_Out), 32'h4);
    chk("s2_busy", 32'(bus.Busy_Out), 1);
    chk("s2_rv0",  32'(bus.Result_Valid_Out), 0);
    step();
    chk("s2_rv",    32'(bus.Result_Valid_Out), 32'h4);
    chk("s2_gnt0",  32'(bus.Gnt_Out), 0);
    chk("s2_flags", 32'(flags()), 32'b100);
    bus.Req_In = '0;
    step();
    chk("s2_idle_rv",   32'(bus.Result_Valid_Out), 0);
    chk("s2_idle_busy", 32'(bus.Busy_Out), 0);

    // Fresh reset, all four requesting: grants 0,1,2,3 every 3 cycles
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    set_ops(0, 16'h0000, 16'h0000);
    set_ops(1, 16'hFFFF, 16'hFFFF);
    set_ops(2, 16'h0000, 16'h0001);
    set_ops(3, 16'h0005, 16'h0003);
    exp027[0] = 3'b010; exp027[1] = 3'b010; exp027[2] = 3'b001; exp027[3] = 3'b100;
    req027 = 4'b1111;
    bus.Req_In = req027;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rr_gnt%0d", k), 32'(bus.Gnt_Out), 32'(1) << k);
      step();
      chk($sformatf("rr_rv%0d", k), 32'(bus.Result_Valid_Out), 32'(1) << k);
      chk($sformatf("rr_flags%0d", k), 32'(flags()), 32'(exp027[k]));
      req027[k] = 1'b0;
      bus.Req_In = req027;
      step();
      chk($sformatf("rr_idle%0d", k), 32'(bus.Gnt_Out), 0);
    end

    // Req0 held plus Req3: alternate 0,3,0,3 (pointer is 0 here)
    set_ops(0, 16'h0007, 16'h0007);
    set_ops(3, 16'h0001, 16'h0002);
    bus.Req_In = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("alt_gnt%0d", k), 32'(bus.Gnt_Out), (k % 2 == 0) ? 32'h1 : 32'h8);
      step();
      chk($sformatf("alt_rv%0d", k), 32'(bus.Result_Valid_Out), (k % 2 == 0) ? 32'h1 : 32'h8);
      chk($sformatf("alt_flags%0d", k), 32'(flags()), (k % 2 == 0) ? 32'b010 : 32'b001);
      step();
    end
    bus.Req_In = '0;

    // No requests: stays idle, flags hold last (lt)
    step(); step();
    chk("nr_gnt",   32'(bus.Gnt_Out), 0);
    chk("nr_rv",    32'(bus.Result_Valid_Out), 0);
    chk("nr_busy",  32'(bus.Busy_Out), 0);
    chk("nr_flags", 32'(flags()), 32'b001);

    // Capture isolation: 0x8000 vs 0x7FFF, operands/Req changed after capture
    bus.Req_In = 4'b0010;
    set_ops(1, 16'h8000, 16'h7FFF);
    step();
    chk("cap_gnt", 32'(bus.Gnt_Out), 32'h2);
    set_ops(1, 16'h0000, 16'hFFFF);
    bus.Req_In = '0;
    step();
    chk("cap_rv",    32'(bus.Result_Valid_Out), 32'h2);
    chk("cap_flags", 32'(flags()), 32'b100);
    step();

    // Reset during COMPARE
    bus.Req_In = 4'b0100;
    set_ops(2, 16'h0001, 16'h0001);
    step();
    chk("mid_gnt", 32'(bus.Gnt_Out), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt",   32'(bus.Gnt_Out), 0);
    chk("mid_rst_busy",  32'(bus.Busy_Out), 0);
    chk("mid_rst_flags", 32'(flags()), 0);
    bus.Req_In = 4'b1010;
    step();
    chk("mid_rst_rv", 32'(bus.Result_Valid_Out), 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("post_rst_gnt", 32'(bus.Gnt_Out), 32'h2);
    step();
    chk("post_rst_rv",    32'(bus.Result_Valid_Out), 32'h2);
    chk("post_rst_flags", 32'(flags()), 32'b001);
    bus.Req_In = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/comparator_arbiter.md
COMPARATOR_ARBITER -- requirements
Module: comparator_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one comparator; fixed at 4 for this release.
REQ-002 Parameter DATA_WIDTH, default 16, operand width; fixed at 16 to match Comparator_16_Bit.
REQ-003 Clock_In  input  1  single clock; all state on rising edge.
REQ-004 Reset_n_In  input  1  asynchronous, active-low reset.
REQ-005 Req_In  input  4  per-requester comparison request, level, held until own result valid.
REQ-006 Data_A_In  input  64  packed operands A; requester i on bits [16i+15:16i].
REQ-007 Data_B_In  input  64  packed operands B; same packing.
REQ-008 Gnt_Out  output  4  one-hot grant, high one cycle in COMPARE.
REQ-009 Busy_Out  output  1  high in COMPARE and REPORT.
REQ-010 Result_Valid_Out  output  4  one-hot, one-cycle pulse in REPORT for the granted requester.
REQ-011 A_gt_B_Out / A_eq_B_Out / A_lt_B_Out  output  1 each  registered unsigned result of last completed comparison.

Function
REQ-012 FSM states SHALL be IDLE, COMPARE, REPORT; IDLE -> COMPARE when any Req_In bit high; COMPARE -> REPORT unconditionally; REPORT -> IDLE unconditionally.
REQ-013 Arbitration SHALL be round-robin: in IDLE, winner is the first asserted Req_In index searching from pointer upward, wrapping 3 -> 0.
REQ-014 On the IDLE -> COMPARE edge the winner index and its A/B operands SHALL be captured into registers; later operand or Req_In changes SHALL NOT affect that comparison.
REQ-015 Comparator Enable_In SHALL be high only in COMPARE, fed from captured operands; comparator outputs SHALL be sampled only on the COMPARE -> REPORT edge (never while high-Z).
REQ-016 Latency: Req_In sampled high in IDLE at edge N -> Gnt_Out at cycle N+1, Result_Valid_Out and updated flags at cycle N+2; throughput one comparison per 3 cycles.
REQ-017 On the REPORT -> IDLE edge pointer SHALL become (winner+1) mod 4.
REQ-018 Exactly one result flag SHALL be high after any completed comparison; flags hold until the next REPORT.
REQ-019 Req_In deasserted after capture SHALL NOT abort; the result still issues.
REQ-020 A requester re-asserting in the cycle after its valid pulse SHALL compete normally with pointer already advanced past it.
REQ-021 No requests: FSM stays in IDLE, Gnt_Out=0, Result_Valid_Out=0, flags held.

Reset
REQ-022 Reset_n_In low SHALL immediately force IDLE, pointer=0, captured registers=0, all outputs 0, including mid-COMPARE or mid-REPORT; no valid pulse issues for an interrupted comparison.
REQ-023 First arbitration after reset release SHALL search from index 0.

Structure
REQ-024 Shared package comparator_arbiter_pkg SHALL hold NUM_REQ, DATA_WIDTH, the state enum, and the index width constant.
REQ-025 Exactly one Comparator_16_Bit instance SHALL be used as sub-module; no other comparison logic on operands.

Verification
REQ-026 Only Req_In=0100, A2=0x0001, B2=0x0000 -> Gnt_Out=0100 at N+1, Result_Valid_Out=0100 at N+2, gt=1 eq=0 lt=0.
REQ-027 Req_In=1111 after reset, held until each valid -> grants in order 0,1,2,3, one every 3 cycles; operands 0x0000/0x0000 -> eq=1; 0xFFFF/0xFFFF -> eq=1; 0x0000/0x0001 -> lt=1.
REQ-028 Req0 continuously high plus Req3 high -> grants alternate 0,3,0,3; neither starved.
REQ-029 Req1 A=0x8000 B=0x7FFF, operands changed to 0x0000/0xFFFF the cycle after capture -> gt=1 (captured values, unsigned).
REQ-030 Reset_n_In low during COMPARE -> all outputs 0 asynchronously, no Result_Valid_Out; after release with Req_In=1010 first grant is index 1.
REQ-031 Bench SHALL score each check against a reference model and report passed/failed/total counts.
